// File: rtl/dac_word_sched.sv
// Buffers the latest 12-bit sample per DAC channel and issues formatted 16-bit command words round-robin,
// at least FRAME_CYCLES apart; a write in idle is issued 2 cycles later; OVERWRITE=0 stalls writes to a pending channel.
module dac_word_sched #(
  parameter int unsigned FRAME_CYCLES = 120,
  parameter bit          OVERWRITE    = 1'b1,
  parameter logic [1:0]  MODE_BITS    = 2'b00
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [1:0]  s_chan,
  input  logic [11:0] s_data,
  output logic [15:0] o_data,
  output logic        o_data_en,
  output logic        o_busy,
  output logic [3:0]  o_pending,
  output logic        o_overrun,
  input  logic        i_overrun_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         sel_q, sel_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [3:0][11:0]   hold_q, hold_d;
  logic [3:0]         pend_q, pend_d;
  logic               ovr_q, ovr_d;
  logic [15:0]        data_q, data_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;

  logic               wr;
  logic               found;
  logic [1:0]         pick;
  logic [1:0]         idx;
  logic               ovr_set;

  assign s_ready   = sys_reset_n & (OVERWRITE ? 1'b1 : ~pend_q[s_chan]);
  assign wr        = s_valid & s_ready;
  assign o_data    = data_q;
  assign o_data_en = en_q;
  assign o_busy    = busy_q;
  assign o_pending = pend_q;
  assign o_overrun = ovr_q;

  // First pending channel at or above the round-robin pointer, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    data_d  = data_q;
    ovr_set = 1'b0;

    case (state_q)
      ISSUE: begin
        pend_d[sel_q] = 1'b0;
        ptr_d         = sel_q + 2'd1;
        cnt_d         = 16'(FRAME_CYCLES - 2);
        state_d       = WAIT;
      end
      default: begin
        // The last WAIT cycle doubles as an IDLE decision so back-to-back issues are exactly FRAME_CYCLES apart.
        if (state_q == WAIT && cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (found) begin
          state_d = ISSUE;
          sel_d   = pick;
          data_d  = {pick, MODE_BITS, hold_q[pick]};
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    // A write after the issue-clear keeps the channel pending for the newer data.
    if (wr) begin
      hold_d[s_chan] = s_data;
      pend_d[s_chan] = 1'b1;
      if (OVERWRITE && pend_q[s_chan] && !(state_q == ISSUE && sel_q == s_chan))
        ovr_set = 1'b1;
    end

    ovr_d  = ovr_set ? 1'b1 : (i_overrun_clr ? 1'b0 : ovr_q);
    en_d   = (state_d == ISSUE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= 16'd0;
      hold_q  <= '0;
      pend_q  <= 4'b0000;
      ovr_q   <= 1'b0;
      data_q  <= 16'h0000;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_dac_word_sched.sv
// Directed bench for dac_word_sched: one OVERWRITE=1 instance, plus an OVERWRITE=0 instance for backpressure.
module tb_dac_word_sched;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b1;
  logic        s_valid = 1'b0;
  logic [1:0]  s_chan = 2'd0;
  logic [11:0] s_data = 12'h000;
  logic        i_overrun_clr = 1'b0;

  logic        s_ready, o_data_en, o_busy, o_overrun;
  logic [15:0] o_data;
  logic [3:0]  o_pending;

  logic        nw_ready, nw_en, nw_busy, nw_overrun;
  logic [15:0] nw_data;
  logic [3:0]  nw_pending;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  logic [15:0] en_data[$];
  int          en_cyc[$];

  always #5 sys_clk = ~sys_clk;

  dac_word_sched #(.FRAME_CYCLES(120), .OVERWRITE(1'b1), .MODE_BITS(2'b00)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_chan(s_chan), .s_data(s_data), .o_data(o_data), .o_data_en(o_data_en),
    .o_busy(o_busy), .o_pending(o_pending), .o_overrun(o_overrun), .i_overrun_clr(i_overrun_clr)
  );

  dac_word_sched #(.FRAME_CYCLES(120), .OVERWRITE(1'b0), .MODE_BITS(2'b00)) dut_nw (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .s_valid(s_valid), .s_ready(nw_ready),
    .s_chan(s_chan), .s_data(s_data), .o_data(nw_data), .o_data_en(nw_en),
    .o_busy(nw_busy), .o_pending(nw_pending), .o_overrun(nw_overrun), .i_overrun_clr(i_overrun_clr)
  );

  always @(negedge sys_clk) begin
    cyc_cnt++;
    if (o_data_en) begin
      en_data.push_back(o_data);
      en_cyc.push_back(cyc_cnt);
    end
  end

  task automatic cyc();
    @(negedge sys_clk);
  endtask

  task automatic clr_q();
    #1;
    en_data.delete();
    en_cyc.delete();
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    i_overrun_clr = 1'b0;
    sys_reset_n = 1'b0;
    repeat (2) cyc();
    sys_reset_n = 1'b1;
    cyc();
  endtask

  task automatic write(input logic [1:0] ch, input logic [11:0] d);
    s_valid = 1'b1;
    s_chan  = ch;
    s_data  = d;
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 sys_reset_n = 1'b0;
    #1;
    checks++; if (o_data !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", o_data); end
    checks++; if ({o_data_en, o_busy, o_overrun} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {o_data_en, o_busy, o_overrun}); end
    checks++; if (o_pending !== 4'b0000) begin failures++; $display("FAIL rst_pending got=%b exp=0000", o_pending); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", s_ready); end
    repeat (2) cyc();
    sys_reset_n = 1'b1;
    cyc();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rel got=%b exp=1", s_ready); end
  endtask

  task automatic test_single_write();
    int n;
    do_reset();
    write(2'd2, 12'hABC);
    checks++; if (o_data_en !== 1'b0 || o_pending !== 4'b0100) begin failures++; $display("FAIL single_cyc1 en=%b pend=%b exp en=0 pend=0100", o_data_en, o_pending); end
    cyc();
    checks++; if (o_data_en !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", o_data_en); end
    checks++; if (o_data !== 16'h8ABC) begin failures++; $display("FAIL single_data got=%h exp=8abc", o_data); end
    cyc();
    checks++; if (o_data_en !== 1'b0 || o_pending !== 4'b0000 || o_data !== 16'h8ABC) begin failures++; $display("FAIL single_after en=%b pend=%b data=%h exp 0/0000/8abc", o_data_en, o_pending, o_data); end
    n = 1;
    while (o_busy && n < 300) begin n++; cyc(); end
    checks++; if (n !== 120) begin failures++; $display("FAIL single_busy got=%0d exp=120", n); end
  endtask

  task automatic test_round_robin();
    do_reset();
    clr_q();
    cyc();
    write(2'd0, 12'h001);
    write(2'd1, 12'h002);
    write(2'd3, 12'h003);
    repeat (400) cyc();
    checks++;
    if (en_data.size() !== 3) begin
      failures++; $display("FAIL rr_count got=%0d exp=3", en_data.size());
    end else begin
      checks++; if (en_data[0] !== 16'h0001 || en_data[1] !== 16'h4002 || en_data[2] !== 16'hC003) begin failures++; $display("FAIL rr_order got=%h %h %h exp=0001 4002 c003", en_data[0], en_data[1], en_data[2]); end
      checks++; if (en_cyc[1] - en_cyc[0] !== 120 || en_cyc[2] - en_cyc[1] !== 120) begin failures++; $display("FAIL rr_spacing got=%0d %0d exp=120 120", en_cyc[1] - en_cyc[0], en_cyc[2] - en_cyc[1]); end
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    write(2'd0, 12'h000);
    cyc();
    clr_q();
    repeat (3) cyc();
    write(2'd1, 12'h111);
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL ovw_first got=%b exp=0", o_overrun); end
    write(2'd1, 12'h222);
    checks++; if (o_overrun !== 1'b1 || o_pending !== 4'b0010) begin failures++; $display("FAIL ovw_set ovr=%b pend=%b exp 1/0010", o_overrun, o_pending); end
    repeat (250) cyc();
    checks++;
    if (en_data.size() !== 1) begin
      failures++; $display("FAIL ovw_count got=%0d exp=1", en_data.size());
    end else begin
      checks++; if (en_data[0] !== 16'h4222) begin failures++; $display("FAIL ovw_data got=%h exp=4222", en_data[0]); end
    end
    checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL ovw_sticky got=%b exp=1", o_overrun); end
    i_overrun_clr = 1'b1;
    cyc();
    i_overrun_clr = 1'b0;
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL ovw_clr got=%b exp=0", o_overrun); end
    write(2'd2, 12'h001);
    i_overrun_clr = 1'b1;
    write(2'd2, 12'h002);
    i_overrun_clr = 1'b0;
    checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL ovw_set_beats_clr got=%b exp=1", o_overrun); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    write(2'd0, 12'h005);
    repeat (3) cyc();
    write(2'd1, 12'h007);
    s_chan = 2'd1;
    #1;
    checks++; if (nw_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_ch1 got=%b exp=0", nw_ready); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ovw_ready_ch1 got=%b exp=1", s_ready); end
    s_chan = 2'd0;
    #1;
    checks++; if (nw_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_ch0 got=%b exp=1", nw_ready); end
    s_chan = 2'd1;
    n = 0;
    while (!nw_en && n < 300) begin
      cyc(); n++;
      if (!nw_en && nw_ready !== 1'b0) begin checks++; failures++; $display("FAIL bp_ready_held got=%b exp=0", nw_ready); end
    end
    checks++; if (nw_en !== 1'b1 || nw_data !== 16'h4007) begin failures++; $display("FAIL bp_issue en=%b data=%h exp 1/4007", nw_en, nw_data); end
    cyc();
    checks++; if (nw_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", nw_ready); end
  endtask

  task automatic test_collision();
    do_reset();
    clr_q();
    write(2'd0, 12'h0AA);
    cyc();
    checks++; if (o_data_en !== 1'b1 || o_data !== 16'h00AA) begin failures++; $display("FAIL col_first en=%b data=%h exp 1/00aa", o_data_en, o_data); end
    write(2'd0, 12'h0BB);
    checks++; if (o_pending !== 4'b0001 || o_overrun !== 1'b0) begin failures++; $display("FAIL col_flags pend=%b ovr=%b exp 0001/0", o_pending, o_overrun); end
    repeat (250) cyc();
    checks++;
    if (en_data.size() !== 2) begin
      failures++; $display("FAIL col_count got=%0d exp=2", en_data.size());
    end else begin
      checks++; if (en_data[0] !== 16'h00AA || en_data[1] !== 16'h00BB) begin failures++; $display("FAIL col_order got=%h %h exp=00aa 00bb", en_data[0], en_data[1]); end
      checks++; if (en_cyc[1] - en_cyc[0] !== 120) begin failures++; $display("FAIL col_spacing got=%0d exp=120", en_cyc[1] - en_cyc[0]); end
    end
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL col_overrun got=%b exp=0", o_overrun); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    write(2'd0, 12'h005);
    cyc();
    write(2'd3, 12'h009);
    repeat (48) cyc();
    checks++; if (o_busy !== 1'b1 || o_pending !== 4'b1000 || o_data !== 16'h0005) begin failures++; $display("FAIL rmw_pre busy=%b pend=%b data=%h exp 1/1000/0005", o_busy, o_pending, o_data); end
    #2 sys_reset_n = 1'b0;
    #1;
    checks++; if (o_data !== 16'h0000 || o_pending !== 4'b0000) begin failures++; $display("FAIL rmw_async data=%h pend=%b exp 0000/0000", o_data, o_pending); end
    checks++; if ({o_data_en, o_busy, o_overrun, s_ready} !== 4'b0000) begin failures++; $display("FAIL rmw_flags got=%b exp=0000", {o_data_en, o_busy, o_overrun, s_ready}); end
    cyc();
    sys_reset_n = 1'b1;
    clr_q();
    repeat (300) cyc();
    checks++; if (en_data.size() !== 0) begin failures++; $display("FAIL rmw_no_issue got=%0d exp=0", en_data.size()); end
    write(2'd3, 12'h00C);
    cyc();
    checks++; if (o_data_en !== 1'b1 || o_data !== 16'hC00C) begin failures++; $display("FAIL rmw_resume en=%b data=%h exp 1/c00c", o_data_en, o_data); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_overwrite();
    test_backpressure();
    test_collision();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
